// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note_on/note_off requests onto NUM_VOICES slots with age tracking.
// Optional macro VOICE_STEAL_EN: when the table is full, a new note_on replaces the oldest active voice.
module voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [3:0]            note,
  input  logic [2:0]            octave,
  input  logic [5:0]            amplitude,
  output logic                  ready,
  output logic [NUM_VOICES-1:0] voice_ld,
  output logic [NUM_VOICES-1:0] voice_off,
  output logic [3:0]            voice_note,
  output logic [2:0]            voice_octave,
  output logic [5:0]            voice_amp,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  stolen,
  output logic                  dropped
);

  localparam int AW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE, SEARCH, LOAD, RELEASE} state_t;

  state_t                state_q, state_d;
  logic                  req_off_q, req_off_d;
  logic [3:0]            note_q, note_d;
  logic [2:0]            oct_q, oct_d;
  logic [5:0]            amp_q, amp_d;
  logic [AW-1:0]         sel_q, sel_d;
  logic                  nofit_q, nofit_d;
  logic                  drop_q, drop_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [3:0]            note_tab_q [NUM_VOICES];
  logic [3:0]            note_tab_d [NUM_VOICES];
  logic [2:0]            oct_tab_q  [NUM_VOICES];
  logic [2:0]            oct_tab_d  [NUM_VOICES];
  logic [AW-1:0]         age_q      [NUM_VOICES];
  logic [AW-1:0]         age_d      [NUM_VOICES];

  logic [NUM_VOICES-1:0] match_vec;
  logic                  match_found, free_found;
  logic [AW-1:0]         match_idx, free_idx;
  logic                  ld_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      assign match_vec[gi] = active_q[gi] && (note_tab_q[gi] == note_q) && (oct_tab_q[gi] == oct_q);
      assign voice_ld[gi]  = ld_fire && (sel_q == AW'(gi));
      assign voice_off[gi] = (state_q == RELEASE) && (sel_q == AW'(gi));
    end
  endgenerate

  // Descending scan so the lowest index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_found = 1'b1;
        match_idx   = AW'(i);
      end
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic          steal_q, steal_d;
  logic [AW-1:0] old_idx, old_age;

  always_comb begin
    old_idx = '0;
    old_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active_q[i] && age_q[i] >= old_age) begin
        old_age = age_q[i];
        old_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) steal_q <= 1'b0;
    else        steal_q <= steal_d;
  end

  assign stolen = ld_fire && steal_q;
`else
  assign stolen = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_off_d  = req_off_q;
    note_d     = note_q;
    oct_d      = oct_q;
    amp_d      = amp_q;
    sel_d      = sel_q;
    nofit_d    = nofit_q;
    drop_d     = 1'b0;
    active_d   = active_q;
    note_tab_d = note_tab_q;
    oct_tab_d  = oct_tab_q;
    age_d      = age_q;
`ifdef VOICE_STEAL_EN
    steal_d    = steal_q;
`endif
    case (state_q)
      IDLE: begin
        if (note_on || note_off) begin
          if (note > 4'd11) begin
            drop_d = 1'b1;
          end else begin
            req_off_d = note_off;
            note_d    = note;
            oct_d     = octave;
            amp_d     = note_off ? 6'd0 : amplitude;
            state_d   = SEARCH;
          end
        end
      end
      SEARCH: begin
        nofit_d = 1'b0;
`ifdef VOICE_STEAL_EN
        steal_d = 1'b0;
`endif
        if (req_off_q) begin
          sel_d   = match_idx;
          state_d = match_found ? RELEASE : IDLE;
        end else begin
          state_d = LOAD;
          if (match_found)     sel_d = match_idx;
          else if (free_found) sel_d = free_idx;
          else begin
`ifdef VOICE_STEAL_EN
            sel_d   = old_idx;
            steal_d = 1'b1;
`else
            nofit_d = 1'b1;
`endif
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        if (!nofit_q) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && (AW'(i) != sel_q) &&
                (!active_q[sel_q] || (age_q[i] < age_q[sel_q])))
              age_d[i] = age_q[i] + AW'(1);
          end
          age_d[sel_q]      = '0;
          active_d[sel_q]   = 1'b1;
          note_tab_d[sel_q] = note_q;
          oct_tab_d[sel_q]  = oct_q;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        // Close the gap left by the released slot so active ranks stay distinct and in range.
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (active_q[i] && (AW'(i) != sel_q) && (age_q[i] > age_q[sel_q]))
            age_d[i] = age_q[i] - AW'(1);
        end
        active_d[sel_q] = 1'b0;
        age_d[sel_q]    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_off_q <= 1'b0;
      note_q    <= '0;
      oct_q     <= '0;
      amp_q     <= '0;
      sel_q     <= '0;
      nofit_q   <= 1'b0;
      drop_q    <= 1'b0;
      active_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_tab_q[i] <= '0;
        oct_tab_q[i]  <= '0;
        age_q[i]      <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_off_q  <= req_off_d;
      note_q     <= note_d;
      oct_q      <= oct_d;
      amp_q      <= amp_d;
      sel_q      <= sel_d;
      nofit_q    <= nofit_d;
      drop_q     <= drop_d;
      active_q   <= active_d;
      note_tab_q <= note_tab_d;
      oct_tab_q  <= oct_tab_d;
      age_q      <= age_d;
    end
  end

  assign ld_fire      = (state_q == LOAD) && !nofit_q;
  assign ready        = (state_q == IDLE);
  assign voice_note   = ld_fire ? note_q : 4'd0;
  assign voice_octave = ld_fire ? oct_q : 3'd0;
  assign voice_amp    = ld_fire ? amp_q : 6'd0;
  assign voice_active = active_q;
  assign dropped      = drop_q || ((state_q == LOAD) && nofit_q);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4); expectations follow VOICE_STEAL_EN when defined.
module tb_voice_allocator;

  logic       clk;
  logic       reset;
  logic       note_on, note_off;
  logic [3:0] note;
  logic [2:0] octave;
  logic [5:0] amplitude;
  logic       ready;
  logic [3:0] voice_ld, voice_off, voice_active;
  logic [3:0] voice_note;
  logic [2:0] voice_octave;
  logic [5:0] voice_amp;
  logic       stolen, dropped;

  int n_vec = 0;
  int n_err = 0;

  logic       s1_ready, s1_drop, s2_stolen, s2_drop, s3_ready;
  logic [3:0] s1_ld, s2_ld, s2_off, s2_note, s3_active;
  logic [2:0] s2_oct;
  logic [5:0] s2_amp;

  voice_allocator #(.NUM_VOICES(4)) dut (
    .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
    .note(note), .octave(octave), .amplitude(amplitude), .ready(ready),
    .voice_ld(voice_ld), .voice_off(voice_off), .voice_note(voice_note),
    .voice_octave(voice_octave), .voice_amp(voice_amp), .voice_active(voice_active),
    .stolen(stolen), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One request: accepted at edge T, samples taken #1 after T, T+1 and T+2.
  task automatic send(input logic on, input logic off, input logic [3:0] n,
                      input logic [2:0] o, input logic [5:0] a);
    @(negedge clk);
    note_on = on; note_off = off; note = n; octave = o; amplitude = a;
    @(posedge clk); #1;
    note_on = 1'b0; note_off = 1'b0;
    s1_ready = ready; s1_drop = dropped; s1_ld = voice_ld;
    @(posedge clk); #1;
    s2_ld = voice_ld; s2_off = voice_off; s2_note = voice_note; s2_oct = voice_octave;
    s2_amp = voice_amp; s2_stolen = stolen; s2_drop = dropped;
    @(posedge clk); #1;
    s3_ready = ready; s3_active = voice_active;
    $display("txn on=%0b off=%0b note=%0d oct=%0d amp=%0d -> ld=%b off=%b drop=%0b/%0b stolen=%0b active=%b",
             on, off, n, o, a, s2_ld, s2_off, s1_drop, s2_drop, s2_stolen, s3_active);
  endtask

  task automatic test_reset();
    reset = 1'b0; note_on = 0; note_off = 0; note = 0; octave = 0; amplitude = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", ready); end
    n_vec++; if (voice_active !== 4'b0000) begin n_err++; $display("FAIL rst_active got %b exp 0000", voice_active); end
    n_vec++; if (voice_ld !== 4'b0000 || voice_off !== 4'b0000) begin n_err++; $display("FAIL rst_pulses got ld=%b off=%b exp 0000", voice_ld, voice_off); end
    n_vec++; if (dropped !== 1'b0 || stolen !== 1'b0) begin n_err++; $display("FAIL rst_flags got drop=%b stolen=%b exp 0", dropped, stolen); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_note_on();
    send(1, 0, 4'd0, 3'd4, 6'd20);
    n_vec++; if (s1_ready !== 1'b0 || s1_ld !== 4'b0000) begin n_err++; $display("FAIL c4_search got ready=%b ld=%b exp 0/0000", s1_ready, s1_ld); end
    n_vec++; if (s2_ld !== 4'b0001) begin n_err++; $display("FAIL c4_ld got %b exp 0001", s2_ld); end
    n_vec++; if (s2_note !== 4'd0 || s2_oct !== 3'd4 || s2_amp !== 6'd20) begin n_err++; $display("FAIL c4_payload got %0d/%0d/%0d exp 0/4/20", s2_note, s2_oct, s2_amp); end
    n_vec++; if (s3_active !== 4'b0001 || s3_ready !== 1'b1) begin n_err++; $display("FAIL c4_active got %b ready=%b exp 0001/1", s3_active, s3_ready); end
    n_vec++; if (voice_ld !== 4'b0000 || voice_note !== 4'd0 || voice_amp !== 6'd0) begin n_err++; $display("FAIL c4_idle_zero got ld=%b note=%0d amp=%0d exp 0", voice_ld, voice_note, voice_amp); end
  endtask

  task automatic test_release();
    send(1, 0, 4'd2, 3'd4, 6'd21);
    n_vec++; if (s2_ld !== 4'b0010) begin n_err++; $display("FAIL d4_ld got %b exp 0010", s2_ld); end
    send(1, 0, 4'd4, 3'd4, 6'd22);
    n_vec++; if (s2_ld !== 4'b0100) begin n_err++; $display("FAIL e4_ld got %b exp 0100", s2_ld); end
    send(1, 0, 4'd5, 3'd4, 6'd23);
    n_vec++; if (s2_ld !== 4'b1000 || s3_active !== 4'b1111) begin n_err++; $display("FAIL f4_ld got %b active=%b exp 1000/1111", s2_ld, s3_active); end
    send(0, 1, 4'd2, 3'd4, 6'd0);
    n_vec++; if (s2_off !== 4'b0010 || s2_ld !== 4'b0000) begin n_err++; $display("FAIL d4_off got off=%b ld=%b exp 0010/0000", s2_off, s2_ld); end
    n_vec++; if (s3_active !== 4'b1101) begin n_err++; $display("FAIL d4_off_active got %b exp 1101", s3_active); end
    send(0, 1, 4'd7, 3'd5, 6'd0);
    n_vec++; if (s2_off !== 4'b0000 || s2_ld !== 4'b0000 || s2_drop !== 1'b0) begin n_err++; $display("FAIL unplayed_off got off=%b ld=%b drop=%b exp 0", s2_off, s2_ld, s2_drop); end
    n_vec++; if (s3_active !== 4'b1101 || s3_ready !== 1'b1) begin n_err++; $display("FAIL unplayed_active got %b ready=%b exp 1101/1", s3_active, s3_ready); end
  endtask

  task automatic test_retrigger();
    send(1, 0, 4'd4, 3'd4, 6'd33);
    n_vec++; if (s2_ld !== 4'b0100 || s2_amp !== 6'd33) begin n_err++; $display("FAIL retrig_ld got %b amp=%0d exp 0100/33", s2_ld, s2_amp); end
    n_vec++; if (s3_active !== 4'b1101) begin n_err++; $display("FAIL retrig_active got %b exp 1101", s3_active); end
    send(1, 0, 4'd7, 3'd4, 6'd10);
    n_vec++; if (s2_ld !== 4'b0010 || s3_active !== 4'b1111) begin n_err++; $display("FAIL g4_ld got %b active=%b exp 0010/1111", s2_ld, s3_active); end
  endtask

  // Ages now: slot0=3, slot1=0, slot2=1 (retriggered), slot3=2.
  task automatic test_full();
    send(1, 0, 4'd9, 3'd4, 6'd40);
`ifdef VOICE_STEAL_EN
    n_vec++; if (s2_ld !== 4'b0001 || s2_stolen !== 1'b1 || s2_drop !== 1'b0) begin n_err++; $display("FAIL steal1 got ld=%b stolen=%b drop=%b exp 0001/1/0", s2_ld, s2_stolen, s2_drop); end
    n_vec++; if (s2_note !== 4'd9 || s2_amp !== 6'd40) begin n_err++; $display("FAIL steal1_payload got %0d/%0d exp 9/40", s2_note, s2_amp); end
`else
    n_vec++; if (s2_ld !== 4'b0000 || s2_drop !== 1'b1 || s2_stolen !== 1'b0) begin n_err++; $display("FAIL full1 got ld=%b drop=%b stolen=%b exp 0000/1/0", s2_ld, s2_drop, s2_stolen); end
`endif
    n_vec++; if (s3_active !== 4'b1111) begin n_err++; $display("FAIL full1_active got %b exp 1111", s3_active); end
    send(1, 0, 4'd11, 3'd4, 6'd41);
`ifdef VOICE_STEAL_EN
    n_vec++; if (s2_ld !== 4'b1000 || s2_stolen !== 1'b1) begin n_err++; $display("FAIL steal2 got ld=%b stolen=%b exp 1000/1", s2_ld, s2_stolen); end
`else
    n_vec++; if (s2_ld !== 4'b0000 || s2_drop !== 1'b1) begin n_err++; $display("FAIL full2 got ld=%b drop=%b exp 0000/1", s2_ld, s2_drop); end
`endif
  endtask

  task automatic test_on_off_and_bad_note();
    send(1, 1, 4'd7, 3'd4, 6'd50);
    n_vec++; if (s2_off !== 4'b0010 || s2_ld !== 4'b0000) begin n_err++; $display("FAIL onoff got off=%b ld=%b exp 0010/0000", s2_off, s2_ld); end
    n_vec++; if (s3_active !== 4'b1101) begin n_err++; $display("FAIL onoff_active got %b exp 1101", s3_active); end
    send(1, 0, 4'd13, 3'd2, 6'd5);
    n_vec++; if (s1_drop !== 1'b1 || s1_ready !== 1'b1 || s1_ld !== 4'b0000) begin n_err++; $display("FAIL bad_note got drop=%b ready=%b ld=%b exp 1/1/0000", s1_drop, s1_ready, s1_ld); end
    n_vec++; if (s2_drop !== 1'b0 || s2_ld !== 4'b0000 || s3_active !== 4'b1101) begin n_err++; $display("FAIL bad_note_after got drop=%b ld=%b active=%b exp 0/0000/1101", s2_drop, s2_ld, s3_active); end
  endtask

  // note_on held for three edges: only the first (ready=1) is taken.
  task automatic test_back_to_back();
    logic [3:0] ld_a;
    logic       rdy_b, rdy_c;
    logic [3:0] ld_c;
    @(negedge clk);
    note_on = 1'b1; note = 4'd0; octave = 3'd5; amplitude = 6'd7;
    @(posedge clk); #1;
    @(posedge clk); #1; ld_a = voice_ld;
    @(posedge clk); #1; rdy_b = ready;
    @(negedge clk); note_on = 1'b0;
    @(posedge clk); #1; rdy_c = ready; ld_c = voice_ld;
    $display("txn held note_on note=0 oct=5 -> ld=%b active=%b", ld_a, voice_active);
    n_vec++; if (ld_a !== 4'b0010) begin n_err++; $display("FAIL busy_ld got %b exp 0010", ld_a); end
    n_vec++; if (rdy_b !== 1'b1 || rdy_c !== 1'b1 || ld_c !== 4'b0000) begin n_err++; $display("FAIL busy_ignored got ready=%b/%b ld=%b exp 1/1/0000", rdy_b, rdy_c, ld_c); end
    n_vec++; if (voice_active !== 4'b1111) begin n_err++; $display("FAIL busy_active got %b exp 1111", voice_active); end
  endtask

  task automatic test_reset_in_search();
    @(negedge clk);
    note_on = 1'b1; note = 4'd3; octave = 3'd2; amplitude = 6'd9;
    @(posedge clk); #1;
    note_on = 1'b0;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rs_in_search got ready=%b exp 0", ready); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    $display("txn reset during search -> ld=%b active=%b ready=%b", voice_ld, voice_active, ready);
    n_vec++; if (voice_ld !== 4'b0000 || dropped !== 1'b0) begin n_err++; $display("FAIL rs_no_ld got ld=%b drop=%b exp 0000/0", voice_ld, dropped); end
    n_vec++; if (voice_active !== 4'b0000 || ready !== 1'b1) begin n_err++; $display("FAIL rs_state got active=%b ready=%b exp 0000/1", voice_active, ready); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (voice_ld !== 4'b0000 || ready !== 1'b1) begin n_err++; $display("FAIL rs_after got ld=%b ready=%b exp 0000/1", voice_ld, ready); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_release();
    test_retrigger();
    test_full();
    test_on_off_and_bad_note();
    test_back_to_back();
    test_reset_in_search();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
